// File: rtl/elevator_pkg.sv
// Shared types, floor constants and direction-mask helpers for the elevator scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR_OPEN
    } state_t;

    localparam int NUM_FLOORS = 3;

    localparam logic [1:0] DEFAULT_LABEL_F1 = 2'b00;
    localparam logic [1:0] DEFAULT_LABEL_F2 = 2'b01;
    localparam logic [1:0] DEFAULT_LABEL_F3 = 2'b10;

    // Floors strictly above / below a floor index (0 = bottom floor).
    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    above_mask = 3'b110;
            2'd1:    above_mask = 3'b100;
            default: above_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [1:0] idx);
        case (idx)
            2'd1:    below_mask = 3'b001;
            2'd2:    below_mask = 3'b011;
            default: below_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_FLOORS-1:0] ahead_mask(input logic [NUM_FLOORS-1:0] pend,
                                                        input logic [1:0] idx,
                                                        input logic up);
        ahead_mask = pend & (up ? above_mask(idx) : below_mask(idx));
    endfunction

    function automatic logic [NUM_FLOORS-1:0] behind_mask(input logic [NUM_FLOORS-1:0] pend,
                                                         input logic [1:0] idx,
                                                         input logic up);
        behind_mask = pend & (up ? below_mask(idx) : above_mask(idx));
    endfunction

endpackage

// File: rtl/elevator_scheduler_timer.sv
// Loadable down-counter shared by travel and door timing; holds at zero.
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN scheduler for a 3-floor cabin: latches calls, sequences travel and door timing.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int         TRAVEL_CYCLES = 16,
    parameter int         DOOR_CYCLES   = 32,
    parameter logic [1:0] LABEL_F1      = DEFAULT_LABEL_F1,
    parameter logic [1:0] LABEL_F2      = DEFAULT_LABEL_F2,
    parameter logic [1:0] LABEL_F3      = DEFAULT_LABEL_F3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [1:0]            floor,
    output logic                  move_handler,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    state_t                  state;
    logic [1:0]              floor_idx;
    logic [1:0]              next_idx;
    logic [NUM_FLOORS-1:0]   here_mask;
    logic [NUM_FLOORS-1:0]   next_mask;
    logic [NUM_FLOORS-1:0]   ahead;
    logic [NUM_FLOORS-1:0]   behind;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [NUM_FLOORS-1:0]   pending_next;
    logic                    call_here;
    logic                    arrive_hit;
    logic                    stationary;
    logic                    timer_load;
    logic [TIMER_W-1:0]      timer_value;
    logic                    timer_zero;

    assign here_mask  = 3'b001 << floor_idx;
    assign next_idx   = dir_up ? floor_idx + 2'd1 : floor_idx - 2'd1;
    assign next_mask  = 3'b001 << next_idx;
    assign call_here  = |(call_req & here_mask);
    assign arrive_hit = |(pending & next_mask);
    assign stationary = (state == IDLE) || (state == DOOR_OPEN);
    assign ahead      = ahead_mask(pending, floor_idx, dir_up);
    assign behind     = behind_mask(pending, floor_idx, dir_up);

    // A call at the floor where the cabin is standing is served by the door, never latched.
    always_comb begin
        clear_mask = '0;
        if (state == MOVE && timer_zero && arrive_hit) begin
            clear_mask = next_mask;
        end
        pending_next = (pending | (call_req & ~(stationary ? here_mask : 3'b000))) & ~clear_mask;
    end

    always_comb begin
        timer_load  = 1'b0;
        timer_value = TRAVEL_LOAD;
        case (state)
            IDLE: begin
                if (call_here) begin
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (|pending) begin
                    timer_load = 1'b1;
                end
            end
            MOVE: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    if (arrive_hit) begin
                        timer_value = DOOR_LOAD;
                    end
                end
            end
            DOOR_OPEN: begin
                if (call_here) begin
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (timer_zero && (|ahead || |behind)) begin
                    timer_load = 1'b1;
                end
            end
            default: begin
                timer_load = 1'b0;
            end
        endcase
    end

    cycle_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(timer_value),
        .zero      (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            floor_idx    <= 2'd0;
            dir_up       <= 1'b1;
            pending      <= '0;
            move_handler <= 1'b0;
            door_open    <= 1'b0;
        end else begin
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (call_here) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                    end else if (|pending) begin
                        state        <= MOVE;
                        move_handler <= 1'b1;
                        if (ahead == '0) begin
                            dir_up <= ~dir_up;
                        end
                    end
                end
                MOVE: begin
                    if (timer_zero) begin
                        floor_idx <= next_idx;
                        if (arrive_hit) begin
                            state        <= DOOR_OPEN;
                            move_handler <= 1'b0;
                            door_open    <= 1'b1;
                        end
                    end
                end
                DOOR_OPEN: begin
                    // A held call keeps the door open; otherwise SCAN decides on expiry.
                    if (!call_here && timer_zero) begin
                        door_open <= 1'b0;
                        if (|ahead) begin
                            state        <= MOVE;
                            move_handler <= 1'b1;
                        end else if (|behind) begin
                            state        <= MOVE;
                            move_handler <= 1'b1;
                            dir_up       <= ~dir_up;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    move_handler <= 1'b0;
                    door_open    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (floor_idx)
            2'd0:    floor = LABEL_F1;
            2'd1:    floor = LABEL_F2;
            default: floor = LABEL_F3;
        endcase
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: stimulus queues expected door sessions, a monitor compares each one as the door closes.
module tb_elevator_scheduler;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] call_req = 3'b000;
    logic [1:0] floor;
    logic       move_handler;
    logic       dir_up;
    logic       door_open;
    logic [2:0] pending;

    typedef struct {
        logic [1:0] floor;
        int         cycles;
        logic [2:0] pend;
        int         travel;
    } door_exp_t;

    door_exp_t  exp_q[$];
    int         checks = 0;
    int         errors = 0;

    bit         in_door = 1'b0;
    int         dcnt = 0;
    int         mcnt = 0;
    int         dtravel = 0;
    logic [1:0] dfloor = 2'b00;
    logic [2:0] dpend = 3'b000;

    elevator_scheduler #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_req    (call_req),
        .floor       (floor),
        .move_handler(move_handler),
        .dir_up      (dir_up),
        .door_open   (door_open),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input int cycles);
        call_req = req;
        stepCycles(cycles);
        call_req = 3'b000;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        stepCycles(2);
        rst_n = 1'b1;
        stepCycles(1);
    endtask

    task automatic pushDoor(input logic [1:0] f, input int cyc, input logic [2:0] p, input int trav);
        door_exp_t e;
        e.floor  = f;
        e.cycles = cyc;
        e.pend   = p;
        e.travel = trav;
        exp_q.push_back(e);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while ((move_handler || door_open || pending != 3'b000) && n < budget) begin
            stepCycles(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
        stepCycles(2);
    endtask

    task automatic waitFloor(input string name, input logic [1:0] f, input int budget);
        int n = 0;
        while (floor !== f && n < budget) begin
            stepCycles(1);
            n++;
        end
        checkOutput(name, floor, f);
    endtask

    task automatic waitDoor(input string name, input int budget);
        int n = 0;
        while (!door_open && n < budget) begin
            stepCycles(1);
            n++;
        end
        checkOutput(name, door_open, 1);
    endtask

    // Monitor: measures each door session and the travel cycles that led to it.
    initial begin : monitor
        door_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_door = 1'b0;
                mcnt    = 0;
            end else begin
                if (floor === 2'b11 || (move_handler && floor == 2'b10 && dir_up) ||
                    (move_handler && floor == 2'b00 && !dir_up)) begin
                    errors++;
                    $display("[TB] FAIL overshoot: floor=%b dir_up=%b move=%b", floor, dir_up, move_handler);
                end
                if (door_open) begin
                    if (!in_door) begin
                        in_door = 1'b1;
                        dfloor  = floor;
                        dpend   = pending;
                        dcnt    = 0;
                        dtravel = mcnt;
                        mcnt    = 0;
                    end
                    dcnt++;
                end else begin
                    if (in_door) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL door_unexpected: got floor=%b cycles=%0d, required no door", dfloor, dcnt);
                        end else begin
                            e = exp_q.pop_front();
                            if (dfloor !== e.floor || dcnt != e.cycles || dpend !== e.pend || dtravel != e.travel) begin
                                errors++;
                                $display("[TB] FAIL door_session: got floor=%b cycles=%0d pend=%b travel=%0d required floor=%b cycles=%0d pend=%b travel=%0d",
                                         dfloor, dcnt, dpend, dtravel, e.floor, e.cycles, e.pend, e.travel);
                            end
                        end
                    end
                    in_door = 1'b0;
                    if (move_handler) mcnt++;
                    else mcnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        // Reset and idle: nothing moves without calls.
        stepCycles(2);
        checkOutput("reset_values", {floor, move_handler, door_open, pending, dir_up}, {2'b00, 1'b0, 1'b0, 3'b000, 1'b1});
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stepCycles(1);
            checkOutput("idle_hold", {floor, move_handler, door_open, pending}, {2'b00, 1'b0, 1'b0, 3'b000});
        end

        // Single call to the top floor.
        pushDoor(2'b10, 3, 3'b000, 8);
        applyStimulus(3'b100, 1);
        checkOutput("t2_latched", {pending, move_handler}, {3'b100, 1'b0});
        stepCycles(1);
        checkOutput("t2_move_start", move_handler, 1);
        stepCycles(3);
        checkOutput("t2_floor_before", floor, 2'b00);
        stepCycles(1);
        checkOutput("t2_floor_f2", {floor, move_handler}, {2'b01, 1'b1});
        stepCycles(4);
        checkOutput("t2_arrive", {floor, door_open, move_handler, pending}, {2'b10, 1'b1, 1'b0, 3'b000});
        waitIdle("t2_idle", 100);
        checkOutput("t2_final", {floor, dir_up}, {2'b10, 1'b1});

        // Door at floor 1 with calls 2 and 3 latched during it.
        applyReset();
        pushDoor(2'b00, 3, 3'b000, 0);
        pushDoor(2'b01, 3, 3'b100, 4);
        pushDoor(2'b10, 3, 3'b000, 4);
        applyStimulus(3'b001, 1);
        checkOutput("t3_door_here", {door_open, pending}, {1'b1, 3'b000});
        applyStimulus(3'b110, 1);
        checkOutput("t3_pending", {door_open, pending}, {1'b1, 3'b110});
        waitIdle("t3_idle", 200);
        checkOutput("t3_final", {floor, dir_up}, {2'b10, 1'b1});

        // Call behind the cabin mid-travel: finish upward first, then reverse.
        applyReset();
        pushDoor(2'b10, 3, 3'b001, 8);
        pushDoor(2'b00, 3, 3'b000, 8);
        applyStimulus(3'b100, 1);
        waitFloor("t4_reach_f2", 2'b01, 20);
        checkOutput("t4_mid", {move_handler, dir_up}, {1'b1, 1'b1});
        applyStimulus(3'b001, 1);
        checkOutput("t4_pending", pending, 3'b101);
        waitIdle("t4_idle", 200);
        checkOutput("t4_final", {floor, dir_up}, {2'b00, 1'b0});

        // Door held at floor 2 by a sustained call; it must never latch.
        pushDoor(2'b01, 8, 3'b000, 4);
        applyStimulus(3'b010, 1);
        waitDoor("t5_door", 30);
        for (int i = 0; i < 5; i++) begin
            call_req = 3'b010;
            stepCycles(1);
            checkOutput("t5_held", {door_open, pending}, {1'b1, 3'b000});
        end
        call_req = 3'b000;
        waitIdle("t5_idle", 100);
        checkOutput("t5_final", {floor, dir_up}, {2'b01, 1'b1});

        // Asynchronous reset in the middle of travel.
        applyReset();
        applyStimulus(3'b010, 1);
        stepCycles(3);
        checkOutput("t6_moving", {move_handler, floor}, {1'b1, 2'b00});
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async", {floor, move_handler, door_open, pending, dir_up}, {2'b00, 1'b0, 1'b0, 3'b000, 1'b1});
        stepCycles(2);
        checkOutput("t6_held", {floor, move_handler, door_open, pending, dir_up}, {2'b00, 1'b0, 1'b0, 3'b000, 1'b1});
        rst_n = 1'b1;
        stepCycles(1);
        pushDoor(2'b01, 3, 3'b000, 4);
        applyStimulus(3'b010, 1);
        waitIdle("t6_idle", 100);
        checkOutput("t6_final", floor, 2'b01);

        checkOutput("door_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
